// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and round-robin search helper for memory port arbiters
package mem_arb_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int MAX_REQ = 8;

  // First set bit strictly after 'last', wrapping modulo n (n <= MAX_REQ); -1 when none is set.
  function automatic int rr_search(input logic [MAX_REQ-1:0] req, input int last, input int n);
    int idx;
    rr_search = -1;
    idx = 0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        idx = (last + k) % n;
        if (req[idx[2:0]]) rr_search = idx;
      end
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rtl/mem_port_arbiter_rr_pick.sv - combinational round-robin picker over a masked request vector
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  input  logic [N-1:0]     mask,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [MAX_REQ-1:0] cand;
  int                 pick;

  always_comb begin
    cand          = '0;
    cand[N-1:0]   = req & mask;
    pick          = rr_search(cand, int'(last), N);
    found         = (pick >= 0);
    idx           = found ? IDX_W'(pick) : '0;
    grant         = '0;
    if (found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory data port, with lock for atomic sequences
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset_n_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ-1:0]        req_lock_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic                      mem_we_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  input  logic [DATA_W-1:0]         mem_rdata_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state, state_next;
  logic [IDX_W-1:0]   last_grant, owner, win_idx;
  logic [NUM_REQ-1:0] mask, grant;
  logic               fire;

  // While locked only the owner is eligible, even when it is idle.
  always_comb begin
    mask = '1;
    if (state == LOCKED) begin
      mask        = '0;
      mask[owner] = 1'b1;
    end
  end

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid_i),
    .last  (last_grant),
    .mask  (mask),
    .grant (grant),
    .idx   (win_idx),
    .found (fire)
  );

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) state <= ARB;
    else            state <= state_next;
  end

  // The winner's lock bit alone decides whether the port stays held.
  always_comb begin
    state_next = state;
    if (fire) state_next = req_lock_i[win_idx] ? LOCKED : ARB;
  end

  always_comb begin
    req_ready_o = grant;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    if (fire) begin
      mem_addr_o  = req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
      mem_wdata_o = req_wdata_i[int'(win_idx)*DATA_W +: DATA_W];
      mem_we_o    = req_we_i[win_idx];
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
    end else if (fire) begin
      last_grant <= win_idx;
      if (req_lock_i[win_idx]) owner <= win_idx;
    end
  end

  // Read data is sampled before the write lands, so write responses carry the old word.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
    end else begin
      rsp_valid_o <= grant;
      if (fire) rsp_rdata_o <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector table and randomized model check for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;

  // two-requester instance for directed vectors
  logic [1:0]  a_valid, a_we, a_lock, a_ready, a_rspv;
  logic [63:0] a_addr, a_wdata;
  logic [31:0] a_rdata, a_maddr, a_mwdata, a_mrdata;
  logic        a_mwe;
  logic [31:0] mem_a [0:255];

  assign a_mrdata = mem_a[a_maddr[7:0]];
  always @(posedge clk) if (a_mwe) mem_a[a_maddr[7:0]] <= a_mwdata;

  mem_port_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(32)) dut_a (
    .clk(clk), .reset_n_i(rst_n),
    .req_valid_i(a_valid), .req_ready_o(a_ready), .req_we_i(a_we), .req_lock_i(a_lock),
    .req_addr_i(a_addr), .req_wdata_i(a_wdata),
    .rsp_valid_o(a_rspv), .rsp_rdata_o(a_rdata),
    .mem_addr_o(a_maddr), .mem_we_o(a_mwe), .mem_wdata_o(a_mwdata), .mem_rdata_i(a_mrdata)
  );

  // four-requester instance for randomized traffic
  logic [3:0]   b_valid, b_we, b_lock, b_ready, b_rspv;
  logic [127:0] b_addr, b_wdata;
  logic [31:0]  b_rdata, b_maddr, b_mwdata, b_mrdata;
  logic         b_mwe;
  logic [31:0]  mem_b [0:255];

  assign b_mrdata = mem_b[b_maddr[7:0]];
  always @(posedge clk) if (b_mwe) mem_b[b_maddr[7:0]] <= b_mwdata;

  mem_port_arbiter #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(32)) dut_b (
    .clk(clk), .reset_n_i(rst_n),
    .req_valid_i(b_valid), .req_ready_o(b_ready), .req_we_i(b_we), .req_lock_i(b_lock),
    .req_addr_i(b_addr), .req_wdata_i(b_wdata),
    .rsp_valid_o(b_rspv), .rsp_rdata_o(b_rdata),
    .mem_addr_o(b_maddr), .mem_we_o(b_mwe), .mem_wdata_o(b_mwdata), .mem_rdata_i(b_mrdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  valid, we, lock;
    logic [7:0]  a0, a1;
    logic [31:0] wd0, wd1;
    logic [1:0]  ready;
    logic        mwe;
    logic [7:0]  maddr;
    logic [1:0]  rspv;
    logic        chkd;
    logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mk(logic [1:0] v, logic [1:0] we, logic [1:0] lk, logic [7:0] a0,
                              logic [7:0] a1, logic [31:0] wd0, logic [31:0] wd1, logic [1:0] rdy,
                              logic mwe, logic [7:0] maddr, logic [1:0] rspv, logic chkd,
                              logic [31:0] rd);
    vec_t t;
    t.valid = v; t.we = we; t.lock = lk; t.a0 = a0; t.a1 = a1; t.wd0 = wd0; t.wd1 = wd1;
    t.ready = rdy; t.mwe = mwe; t.maddr = maddr; t.rspv = rspv; t.chkd = chkd; t.rdata = rd;
    return t;
  endfunction

  vec_t vecs [18];

  task automatic drive_a(logic [1:0] v, logic [1:0] we, logic [1:0] lk, logic [7:0] a0,
                         logic [7:0] a1, logic [31:0] wd0, logic [31:0] wd1);
    a_valid = v; a_we = we; a_lock = lk;
    a_addr  = {24'h0, a1, 24'h0, a0};
    a_wdata = {wd1, wd0};
  endtask

  // randomized reference state
  bit          pv [4], pwe [4], plock [4];
  int          paddr [4];
  logic [31:0] pwd [4];
  logic [31:0] ref_b [0:15];
  bit          m_locked;
  int          m_owner, m_last, w, idx;
  logic [3:0]  exp_rdy;
  logic [31:0] exp_d;

  initial begin
    rst_n = 1'b0;
    drive_a(2'b00, 2'b00, 2'b00, 8'h0, 8'h0, 32'h0, 32'h0);
    b_valid = '0; b_we = '0; b_lock = '0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[8'h10] = 32'hDEADBEEF;
    mem_a[8'h30] = 32'hA5A50030;
    for (int i = 0; i < 16; i++) begin
      mem_b[i] = $urandom;
      ref_b[i] = mem_b[i];
    end

    #2;
    chk("reset_rsp_valid", {62'h0, a_rspv}, 64'h0);
    chk("reset_rsp_rdata", {32'h0, a_rdata}, 64'h0);
    chk("reset_ready_idle", {62'h0, a_ready}, 64'h0);
    chk("reset_mem_we", {63'h0, a_mwe}, 64'h0);
    chk("reset_mem_addr", {32'h0, a_maddr}, 64'h0);
    chk("reset_b_rsp_valid", {60'h0, b_rspv}, 64'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      vecs[i] = (i % 2 == 0)
        ? mk(2'b11, 2'b00, 2'b00, 8'h10, 8'h30, 0, 0, 2'b01, 0, 8'h10, 2'b01, 1, 32'hDEADBEEF)
        : mk(2'b11, 2'b00, 2'b00, 8'h10, 8'h30, 0, 0, 2'b10, 0, 8'h30, 2'b10, 1, 32'hA5A50030);
    vecs[6]  = mk(2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 0, 0, 2'b01, 0, 8'h10, 2'b01, 1, 32'hDEADBEEF);
    vecs[7]  = mk(2'b01, 2'b01, 2'b00, 8'h20, 8'h00, 32'h12345678, 0, 2'b01, 1, 8'h20, 2'b01, 0, 0);
    vecs[8]  = mk(2'b10, 2'b00, 2'b00, 8'h00, 8'h20, 0, 0, 2'b10, 0, 8'h20, 2'b10, 1, 32'h12345678);
    vecs[9]  = mk(2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 0, 0, 2'b01, 0, 8'h10, 2'b01, 1, 32'hDEADBEEF);
    vecs[10] = mk(2'b11, 2'b00, 2'b10, 8'h10, 8'h30, 0, 0, 2'b10, 0, 8'h30, 2'b10, 1, 32'hA5A50030);
    vecs[11] = mk(2'b11, 2'b10, 2'b00, 8'h10, 8'h30, 0, 32'hCAFEF00D, 2'b10, 1, 8'h30, 2'b10, 0, 0);
    vecs[12] = mk(2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 0, 0, 2'b01, 0, 8'h10, 2'b01, 1, 32'hDEADBEEF);
    vecs[13] = mk(2'b01, 2'b00, 2'b01, 8'h10, 8'h00, 0, 0, 2'b01, 0, 8'h10, 2'b01, 1, 32'hDEADBEEF);
    for (int i = 14; i < 18; i++)
      vecs[i] = mk(2'b10, 2'b00, 2'b00, 8'h00, 8'h30, 0, 0, 2'b00, 0, 8'h00, 2'b00, 0, 0);

    foreach (vecs[i]) begin
      drive_a(vecs[i].valid, vecs[i].we, vecs[i].lock, vecs[i].a0, vecs[i].a1, vecs[i].wd0, vecs[i].wd1);
      #3;
      chk($sformatf("v%0d_ready", i), {62'h0, a_ready}, {62'h0, vecs[i].ready});
      chk($sformatf("v%0d_mem_we", i), {63'h0, a_mwe}, {63'h0, vecs[i].mwe});
      chk($sformatf("v%0d_mem_addr", i), {32'h0, a_maddr}, {56'h0, vecs[i].maddr});
      @(posedge clk); #1;
      chk($sformatf("v%0d_rsp_valid", i), {62'h0, a_rspv}, {62'h0, vecs[i].rspv});
      if (vecs[i].chkd) chk($sformatf("v%0d_rsp_rdata", i), {32'h0, a_rdata}, {32'h0, vecs[i].rdata});
    end

    // reset while locked with a response in flight
    drive_a(2'b01, 2'b00, 2'b01, 8'h10, 8'h00, 0, 0);
    #3 chk("relock_ready", {62'h0, a_ready}, 64'h1);
    @(posedge clk); #1;
    chk("relock_rsp_valid", {62'h0, a_rspv}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_rsp_valid", {62'h0, a_rspv}, 64'h0);
    chk("async_rst_rsp_rdata", {32'h0, a_rdata}, 64'h0);
    #1 rst_n = 1'b1;
    drive_a(2'b10, 2'b00, 2'b00, 8'h00, 8'h30, 0, 0);
    #1;
    chk("post_rst_ready", {62'h0, a_ready}, 64'h2);
    chk("post_rst_mem_addr", {32'h0, a_maddr}, 64'h30);
    @(posedge clk); #1;
    chk("post_rst_rsp_valid", {62'h0, a_rspv}, 64'h2);
    chk("post_rst_rsp_rdata", {32'h0, a_rdata}, 64'hCAFEF00D);
    drive_a(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 0, 0);

    m_locked = 1'b0; m_owner = 0; m_last = 3;
    for (int i = 0; i < 4; i++) pv[i] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pv[i] && $urandom_range(1, 0) == 1) begin
          pv[i]    = 1'b1;
          pwe[i]   = 1'($urandom_range(1, 0));
          plock[i] = ($urandom_range(3, 0) == 0);
          paddr[i] = $urandom_range(15, 0);
          pwd[i]   = $urandom;
        end
        b_valid[i] = pv[i]; b_we[i] = pwe[i]; b_lock[i] = plock[i];
        b_addr[i*32 +: 32]  = 32'(paddr[i]);
        b_wdata[i*32 +: 32] = pwd[i];
      end
      #3;
      w = -1;
      if (m_locked) begin
        if (pv[m_owner]) w = m_owner;
      end else begin
        for (int k = 1; k <= 4; k++) begin
          idx = (m_last + k) % 4;
          if (w < 0 && pv[idx]) w = idx;
        end
      end
      exp_rdy = (w >= 0) ? 4'(1 << w) : 4'h0;
      chk("rand_ready", {60'h0, b_ready}, {60'h0, exp_rdy});
      chk("rand_mem_we", {63'h0, b_mwe}, (w >= 0) ? {63'h0, pwe[w]} : 64'h0);
      chk("rand_mem_addr", {32'h0, b_maddr}, (w >= 0) ? 64'(paddr[w]) : 64'h0);
      chk("rand_mem_wdata", {32'h0, b_mwdata}, (w >= 0) ? {32'h0, pwd[w]} : 64'h0);
      if (w >= 0) begin
        exp_d = ref_b[paddr[w]];
        if (pwe[w]) ref_b[paddr[w]] = pwd[w];
        m_last   = w;
        m_locked = plock[w];
        m_owner  = w;
        pv[w]    = 1'b0;
      end
      @(posedge clk); #1;
      chk("rand_rsp_valid", {60'h0, b_rspv}, {60'h0, exp_rdy});
      if (w >= 0) chk("rand_rsp_rdata", {32'h0, b_rdata}, {32'h0, exp_d});
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data port of the dual-port memory between NUM_REQ bus masters, e.g. CPU load/store unit and a DMA/video fetcher.
- Arbitration is round-robin, one access per cycle, with a lock option for atomic multi-access sequences (read-modify-write).
- Drives the memory data port's address, write-enable and write-data, and samples its combinational read data.
- Returns registered responses to requesters one cycle after grant.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, address width of requests and memory port
DATA_W, 32, data word width

Ports:
clk  in  1  system clock, rising edge
reset_n_i  in  1  asynchronous active-low reset
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester grant/accept (one-hot or zero)
req_we_i  in  NUM_REQ  per-requester write enable
req_lock_i  in  NUM_REQ  keep grant after this access
req_addr_i  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata_i  in  NUM_REQ*DATA_W  packed write data
rsp_valid_o  out  NUM_REQ  one-cycle response strobe to the served requester
rsp_rdata_o  out  DATA_W  registered read data, shared by all requesters
mem_addr_o  out  ADDR_W  to memory data-port address
mem_we_o  out  1  to memory data-port write enable
mem_wdata_o  out  DATA_W  to memory data-port write data
mem_rdata_i  in  DATA_W  from memory data-port read data (combinational on mem_addr_o)

Behaviour:
- Reset (async, reset_n_i low):
  - state=ARB, last_grant=NUM_REQ-1, owner=0
  - rsp_valid_o=0, rsp_rdata_o=0
- Handshake: accepted on a rising edge where req_valid_i[i] & req_ready_o[i].
  - req_ready_o is combinational from req_valid_i and state; at most one bit set.
  - A requester must hold valid/we/lock/addr/wdata stable until its handshake.
- State ARB:
  - Winner is the first valid requester searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - The winner gets ready. No valid requester means no grant.
- State LOCKED:
  - Only owner may be granted. Others see ready=0 even if owner is idle.
- Memory drive:
  - During a grant, mem_addr_o/mem_wdata_o come from the winner and mem_we_o=req_we_i[winner].
  - Without a grant: mem_addr_o=0, mem_wdata_o=0, mem_we_o=0.
- Transitions on handshake by requester i:
  - last_grant<=i.
  - ARB with lock=1 -> LOCKED, owner<=i. ARB with lock=0 -> ARB.
  - LOCKED with lock=0 -> ARB. LOCKED with lock=1 -> stays LOCKED.
- Response, latency 1 cycle for reads and writes:
  - On the handshake edge, rsp_rdata_o<=mem_rdata_i and rsp_valid_o<=one-hot(i).
  - Otherwise rsp_valid_o<=0 and rsp_rdata_o holds its value.
  - For writes, rsp_rdata_o captures the pre-write word. It is an ack only; the content is don't-care to requesters.
- Back-to-back: a new grant is allowed every cycle. Throughput is 1 access/cycle. Response pipeline has no backpressure.
- Write-then-read, same address, consecutive cycles: the read returns the newly written word.
- Fairness: with all requesters continuously valid and no locks, grants rotate 0,1,...,NUM_REQ-1,0.
- Reset mid-LOCKED or with a pending response: returns to ARB and drops rsp_valid_o immediately.
- Lock with no progress: LOCKED persists indefinitely while owner holds valid low. No timeout; owner is responsible for release.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {ARB, LOCKED}
  - helper function for round-robin search from a start index (also used by future arbiters)
- One sub-module: rr_pick. Combinational; inputs req vector, last index, mask; outputs one-hot grant plus index.
- The top holds the FSM, last_grant/owner registers, memory muxing and response registers.

Test Plan:
- Reset, then req_valid=2'b01, we=0, addr=0x10 with mem[0x10]=0xDEADBEEF -> ready=2'b01 same cycle; next cycle rsp_valid=2'b01, rsp_rdata=0xDEADBEEF.
- Both requesters valid every cycle for 6 cycles -> ready sequence 01,10,01,10,01,10; rsp_valid matches, delayed one cycle.
- Req0 write addr=0x20, data=0x12345678, then req1 read addr=0x20 next cycle -> mem_we_o=1 for one cycle; req1 rsp_rdata=0x12345678.
- Req1 reads 0x30 with lock=1 and writes 0x30 with lock=0, req0 valid throughout -> req0 gets ready=0 for 2 grant cycles, then is granted on the cycle after the unlock.
- Req0 locked then deasserts valid for 3 cycles, req1 valid -> no grants, mem_we_o=0, mem_addr_o=0 during those cycles.
- Assert reset_n_i low mid-LOCKED with rsp_valid high -> rsp_valid=0 asynchronously; after release, req1 alone is granted in 1 cycle.
